// File: rtl/uart_pkg.sv
// Shared definitions for the UART command receiver and the PWM duty stage.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [7:0] CMD_OFF  = 8'h30;
    localparam logic [7:0] CMD_MID  = 8'h63;
    localparam logic [7:0] CMD_FULL = 8'h78;

    // 50 MHz system clock, 9600 baud
    localparam int CLKS_PER_BIT_DEFAULT = 5208;

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Serial line in, received command byte and status strobes out.
// master drives rx and watches the results; slave is the receiver.
interface uart_rx_cmd_if;
    import uart_pkg::*;

    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    state_t     state;

    modport master (output rx, input data, data_valid, frame_err, busy, state);
    modport slave  (input rx, output data, data_valid, frame_err, busy, state);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cmd.sv
// UART 8N1 receiver holding the last correctly framed byte for the PWM stage.
// data_valid / frame_err are one-cycle strobes; busy is high outside IDLE.
module uart_rx_cmd
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0] RESET_BYTE   = CMD_OFF
) (
    input logic          clk,
    input logic          rst_n,
    uart_rx_cmd_if.slave bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_s;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= RESET_BYTE;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= START;
                end
                // Re-check the start bit mid-bit so short low glitches are dropped.
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                // A line held low after a bad stop must return high before a new start.
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data       = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state != IDLE);
    assign bus.state      = state;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: directed table, corner sequences, random frames.
module tb_uart_rx_cmd;
    import uart_pkg::*;

    localparam int C       = 16;
    localparam int LATENCY = 2 + C / 2 + 9 * C + 1;

    typedef struct {
        logic [7:0] payload;
        logic       stop_ok;
        int         hold_low;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    logic clk;
    logic rst_n;

    uart_rx_cmd_if bus ();

    uart_rx_cmd #(.CLKS_PER_BIT(C), .RESET_BYTE(8'h30)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_seen = 0;
    int both_seen = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_data;
    int exp_ferr_total;

    // output monitor, sampled 1 time unit after the active edge
    always @(posedge clk) begin
        #1;
        if (bus.data_valid) got_q.push_back(bus.data);
        if (bus.frame_err) ferr_seen++;
        if (bus.data_valid && bus.frame_err) both_seen++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Caller is at a negedge; leaves rx at the stop level, at a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        bus.rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (C) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (C) @(negedge clk);
    endtask

    // Reference model: a good frame yields that byte, a bad stop leaves data alone.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_q.push_back(b);
            model_data = b;
        end else begin
            exp_ferr_total++;
        end
    endtask

    task automatic sb_drain(input string name);
        logic [7:0] e;
        logic [7:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() == 0) begin
                check({name, "_missing"}, 32'h0, 32'h1);
            end else begin
                g = got_q.pop_front();
                check(name, {24'h0, g}, {24'h0, e});
            end
        end
        check({name, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int v0;
        int f0;
        int n;
        logic [7:0] b;
        logic ok;

        vecs[0] = '{8'h63, 1'b1, 0, 8'h63, 1, 0};
        vecs[1] = '{8'h78, 1'b1, 0, 8'h78, 1, 0};
        vecs[2] = '{8'h30, 1'b1, 0, 8'h30, 1, 0};
        vecs[3] = '{8'h00, 1'b1, 0, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 0, 8'hFF, 1, 0};
        vecs[5] = '{8'h55, 1'b0, 40, 8'hFF, 0, 1};
        vecs[6] = '{8'hA5, 1'b1, 0, 8'hA5, 1, 0};
        model_data = 8'h30;
        exp_ferr_total = 0;

        // 1. reset with idle line
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        idle(3);
        check("reset_data", {24'h0, bus.data}, 32'h30);
        check("reset_valid", {31'h0, bus.data_valid}, 0);
        check("reset_ferr", {31'h0, bus.frame_err}, 0);
        check("reset_busy", {31'h0, bus.busy}, 0);
        check("reset_state", {29'h0, bus.state}, {29'h0, IDLE});
        rst_n = 1'b1;
        idle(5);

        // 2. single frame with latency measurement
        n = 0;
        fork
            send_frame(CMD_MID, 1'b1);
            begin
                while (n < 400) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (bus.data_valid) break;
                end
            end
        join
        model_frame(CMD_MID, 1'b1);
        check("latency", n, LATENCY);
        idle(10);
        check("first_data", {24'h0, bus.data}, 32'h63);
        sb_drain("first_frame");

        // 3. back-to-back frames, no idle gap
        send_frame(CMD_FULL, 1'b1);
        model_frame(CMD_FULL, 1'b1);
        check("b2b_mid_data", {24'h0, bus.data}, 32'h78);
        send_frame(CMD_OFF, 1'b1);
        model_frame(CMD_OFF, 1'b1);
        idle(10);
        check("b2b_data", {24'h0, bus.data}, 32'h30);
        sb_drain("b2b");

        // 4. four-cycle low glitch
        v0 = got_q.size();
        f0 = ferr_seen;
        bus.rx = 1'b0;
        idle(4);
        bus.rx = 1'b1;
        idle(40);
        check("glitch_valid", got_q.size(), v0);
        check("glitch_ferr", ferr_seen, f0);
        check("glitch_data", {24'h0, bus.data}, 32'h30);
        check("glitch_busy", {31'h0, bus.busy}, 0);

        // table of directed frames (includes bad stop held low)
        for (int i = 0; i < 7; i++) begin
            v0 = got_q.size();
            f0 = ferr_seen;
            send_frame(vecs[i].payload, vecs[i].stop_ok);
            if (vecs[i].hold_low > 0) begin
                idle(vecs[i].hold_low);
                check($sformatf("vec%0d_busy_low", i), {31'h0, bus.busy}, 1);
                bus.rx = 1'b1;
            end
            idle(6);
            check($sformatf("vec%0d_data", i), {24'h0, bus.data}, {24'h0, vecs[i].exp_data});
            check($sformatf("vec%0d_valid", i), got_q.size() - v0, vecs[i].exp_valid);
            check($sformatf("vec%0d_ferr", i), ferr_seen - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d_busy", i), {31'h0, bus.busy}, 0);
            model_frame(vecs[i].payload, vecs[i].stop_ok);
        end
        sb_drain("table");

        // random frames against the model
        for (int i = 0; i < 24; i++) begin
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, ok);
            model_frame(b, ok);
            if (!ok) begin
                idle($urandom_range(0, 30));
                bus.rx = 1'b1;
                idle(3);
            end
            idle($urandom_range(0, 5));
        end
        idle(10);
        check("rand_data", {24'h0, bus.data}, {24'h0, model_data});
        check("rand_ferr_total", ferr_seen, exp_ferr_total);
        sb_drain("random");

        // 6. reset in the middle of a frame, then a clean frame
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b1);
        idle(5);
        bus.rx = 1'b0;
        idle(C);
        for (int i = 0; i < 3; i++) begin
            bus.rx = CMD_FULL[i];
            idle(C);
        end
        check("pre_abort_busy", {31'h0, bus.busy}, 1);
        rst_n = 1'b0;
        #1;
        check("abort_data", {24'h0, bus.data}, 32'h30);
        check("abort_busy", {31'h0, bus.busy}, 0);
        bus.rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        model_data = 8'h30;
        idle(5);
        send_frame(CMD_MID, 1'b1);
        model_frame(CMD_MID, 1'b1);
        idle(10);
        check("post_reset_data", {24'h0, bus.data}, 32'h63);
        sb_drain("reset_abort");

        check("strobes_exclusive", both_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
